// File: rtl/cordic_rotate.sv
// Pipelined rotation-mode CORDIC: quadrant pre-rotation, STAGES micro-rotations,
// saturating output. Code and valid travel with their data slot.
module cordic_rotate #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 12,
    parameter int STAGES     = 12,
    parameter int CODE_WIDTH = 8,
    parameter int GUARD      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      x_in,
    input  logic [WIDTH-1:0]      y_in,
    input  logic [15:0]           angle_in,
    input  logic [CODE_WIDTH-1:0] code_in,
    input  logic                  valid_in,
    output logic [WIDTH-1:0]      x_out,
    output logic [WIDTH-1:0]      y_out,
    output logic [CODE_WIDTH-1:0] code_out,
    output logic                  valid_out
);

    localparam int IW = WIDTH + GUARD;
    localparam int ZW = 17;

    if (STAGES < 1 || STAGES > 14 || FRAC_BITS >= WIDTH) begin : g_param_check
        $error("cordic_rotate: illegal parameter set");
    end

    logic signed [IW-1:0]   x_q [0:STAGES];
    logic signed [IW-1:0]   x_d [0:STAGES];
    logic signed [IW-1:0]   y_q [0:STAGES];
    logic signed [IW-1:0]   y_d [0:STAGES];
    logic signed [ZW-1:0]   z_q [0:STAGES];
    logic signed [ZW-1:0]   z_d [0:STAGES];
    logic [CODE_WIDTH-1:0]  code_q [0:STAGES];
    logic [CODE_WIDTH-1:0]  code_d [0:STAGES];
    logic                   valid_q [0:STAGES];
    logic                   valid_d [0:STAGES];

    logic signed [IW-1:0]   x_ext;
    logic signed [IW-1:0]   y_ext;
    logic                   flip;
    logic [15:0]            angle0;

    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        case (i)
            0:       return 17'sd8192;
            1:       return 17'sd4836;
            2:       return 17'sd2555;
            3:       return 17'sd1297;
            4:       return 17'sd651;
            5:       return 17'sd326;
            6:       return 17'sd163;
            7:       return 17'sd81;
            8:       return 17'sd41;
            9:       return 17'sd20;
            10:      return 17'sd10;
            11:      return 17'sd5;
            12:      return 17'sd3;
            13:      return 17'sd1;
            default: return 17'sd0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (&v[IW-1:WIDTH-1] || ~|v[IW-1:WIDTH-1])
            return v[WIDTH-1:0];
        return v[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        x_ext  = {{GUARD{x_in[WIDTH-1]}}, x_in};
        y_ext  = {{GUARD{y_in[WIDTH-1]}}, y_in};
        // angle in the outer half-plane: rotate by pi first, which flips bit 15
        flip   = angle_in[15] ^ angle_in[14];
        angle0 = flip ? {~angle_in[15], angle_in[14:0]} : angle_in;

        x_d[0]     = flip ? -x_ext : x_ext;
        y_d[0]     = flip ? -y_ext : y_ext;
        z_d[0]     = {angle0[15], angle0};
        code_d[0]  = code_in;
        valid_d[0] = valid_in;

        for (int i = 0; i < STAGES; i++) begin
            if (!z_q[i][ZW-1]) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - atan_lut(i);
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + atan_lut(i);
            end
            code_d[i+1]  = code_q[i];
            valid_d[i+1] = valid_q[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= STAGES; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                z_q[i]     <= '0;
                code_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (enable) begin
            for (int i = 0; i <= STAGES; i++) begin
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                z_q[i]     <= z_d[i];
                code_q[i]  <= code_d[i];
                valid_q[i] <= valid_d[i];
            end
        end
    end

    assign x_out     = sat(x_q[STAGES]);
    assign y_out     = sat(y_q[STAGES]);
    assign code_out  = code_q[STAGES];
    assign valid_out = valid_q[STAGES];

endmodule

// File: tb/tb_cordic_rotate.sv
// Bench for cordic_rotate: delay-line scoreboard fed by an integer CORDIC
// reference plus ideal trig checks for the directed cases.
module tb_cordic_rotate;

    localparam int LAT = 13;
    localparam int TOL = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [15:0] angle_in = '0;
    logic [7:0]  code_in = '0;
    logic        valid_in = 1'b0;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [7:0]  code_out;
    logic        valid_out;

    typedef struct {
        logic        v;
        logic [7:0]  c;
        logic [15:0] x;
        logic [15:0] y;
    } slot_t;

    slot_t pipe[$];
    int    total = 0;
    int    bad = 0;
    real   kgain;
    int    atan_tab [14] = '{8192, 4836, 2555, 1297, 651, 326, 163,
                             81, 41, 20, 10, 5, 3, 1};

    cordic_rotate dut (
        .clock(clock), .reset(reset), .enable(enable),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .code_in(code_in), .valid_in(valid_in),
        .x_out(x_out), .y_out(y_out),
        .code_out(code_out), .valid_out(valid_out)
    );

    always #5 clock = ~clock;

    function automatic int clamp16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic slot_t model(logic v, logic [7:0] c,
                                    logic [15:0] xs, logic [15:0] ys,
                                    logic [15:0] a);
        slot_t s;
        int x, y, z, xn;
        x = int'($signed(xs));
        y = int'($signed(ys));
        z = int'($signed(a));
        if (z >= 16384) begin
            x = -x; y = -y; z = z - 32768;
        end else if (z < -16384) begin
            x = -x; y = -y; z = z + 32768;
        end
        for (int i = 0; i < 12; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_tab[i];
            end
            x = xn;
        end
        s.v = v;
        s.c = c;
        s.x = 16'(clamp16(x));
        s.y = 16'(clamp16(y));
        return s;
    endfunction

    function automatic int ideal(int x, int y, int a, bit want_y);
        real th, r;
        th = real'(a) * 3.14159265358979 / 32768.0;
        if (want_y) r = kgain * (real'(x) * $sin(th) + real'(y) * $cos(th));
        else        r = kgain * (real'(x) * $cos(th) - real'(y) * $sin(th));
        return clamp16($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
    endfunction

    task automatic pipe_clear();
        slot_t z;
        z.v = 1'b0; z.c = '0; z.x = '0; z.y = '0;
        pipe.delete();
        repeat (LAT) pipe.push_back(z);
    endtask

    task automatic drive(input logic v, input logic [7:0] c,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] a);
        valid_in = v; code_in = c; x_in = x; y_in = y; angle_in = a;
    endtask

    task automatic step();
        @(posedge clock);
        if (enable && !reset) begin
            pipe.push_back(model(valid_in, code_in, x_in, y_in, angle_in));
            void'(pipe.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #2 reset = 1'b1;
        #2;
        total++;
        if ({valid_out, code_out, x_out, y_out} !== 41'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b c=%h x=%h y=%h want all zero",
                     valid_out, code_out, x_out, y_out);
        end
        @(negedge clock) reset = 1'b0;
        pipe_clear();
    endtask

    task automatic test_latency();
        int ix, iy;
        drive(1'b1, 8'hA5, 16'd2487, 16'd0, 16'd0);
        step();
        drive(1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) step();
            total++;
            if (valid_out !== (k == LAT)) begin
                bad++;
                $display("FAIL latency_valid clk=%0d got=%b want=%b", k, valid_out, k == LAT);
            end
        end
        ix = ideal(2487, 0, 0, 1'b0);
        iy = ideal(2487, 0, 0, 1'b1);
        total++;
        if (code_out !== 8'hA5 || x_out !== pipe[0].x || y_out !== pipe[0].y) begin
            bad++;
            $display("FAIL latency_data got c=%h x=%0d y=%0d want c=a5 x=%0d y=%0d",
                     code_out, $signed(x_out), $signed(y_out),
                     $signed(pipe[0].x), $signed(pipe[0].y));
        end
        total++;
        if ($signed(x_out) - ix > TOL || ix - $signed(x_out) > TOL ||
            $signed(y_out) - iy > TOL || iy - $signed(y_out) > TOL) begin
            bad++;
            $display("FAIL latency_ideal got x=%0d y=%0d want x=%0d y=%0d",
                     $signed(x_out), $signed(y_out), ix, iy);
        end
        step();
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL latency_single got valid=%b want 0", valid_out);
        end
    endtask

    task automatic test_quadrants();
        int angs [5] = '{16384, 8192, -32768, -16384, 24576};
        int ix, iy;
        for (int q = 0; q < 5; q++) begin
            drive(1'b1, 8'(q), 16'd2487, 16'd0, 16'(angs[q]));
            step();
            drive(1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
            repeat (LAT - 1) step();
            ix = ideal(2487, 0, angs[q], 1'b0);
            iy = ideal(2487, 0, angs[q], 1'b1);
            total++;
            if (valid_out !== 1'b1 || code_out !== 8'(q) ||
                x_out !== pipe[0].x || y_out !== pipe[0].y) begin
                bad++;
                $display("FAIL quadrant_exact ang=%0d got v=%b x=%0d y=%0d want x=%0d y=%0d",
                         angs[q], valid_out, $signed(x_out), $signed(y_out),
                         $signed(pipe[0].x), $signed(pipe[0].y));
            end
            total++;
            if ($signed(x_out) - ix > TOL || ix - $signed(x_out) > TOL ||
                $signed(y_out) - iy > TOL || iy - $signed(y_out) > TOL) begin
                bad++;
                $display("FAIL quadrant_ideal ang=%0d got x=%0d y=%0d want x=%0d y=%0d",
                         angs[q], $signed(x_out), $signed(y_out), ix, iy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nexp = 0;
        int a, ix, iy;
        for (int t = 0; t < 64 + LAT; t++) begin
            if (t < 64) drive(1'b1, 8'(t), 16'd2487, 16'd0, 16'(t * 1024));
            else        drive(1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
            step();
            total++;
            if ({valid_out, code_out, x_out, y_out} !==
                {pipe[0].v, pipe[0].c, pipe[0].x, pipe[0].y}) begin
                bad++;
                $display("FAIL stream_slot t=%0d got v=%b c=%h x=%h y=%h want v=%b c=%h x=%h y=%h",
                         t, valid_out, code_out, x_out, y_out,
                         pipe[0].v, pipe[0].c, pipe[0].x, pipe[0].y);
            end
            if (valid_out === 1'b1) begin
                a  = int'($signed(16'(nexp * 1024)));
                ix = ideal(2487, 0, a, 1'b0);
                iy = ideal(2487, 0, a, 1'b1);
                total++;
                if (code_out !== 8'(nexp) ||
                    $signed(x_out) - ix > TOL || ix - $signed(x_out) > TOL ||
                    $signed(y_out) - iy > TOL || iy - $signed(y_out) > TOL) begin
                    bad++;
                    $display("FAIL stream_order n=%0d got c=%0d x=%0d y=%0d want c=%0d x=%0d y=%0d",
                             nexp, code_out, $signed(x_out), $signed(y_out), nexp, ix, iy);
                end
                nexp++;
            end
        end
        total++;
        if (nexp != 64) begin
            bad++;
            $display("FAIL stream_count got=%0d want=64", nexp);
        end
    endtask

    task automatic test_stall();
        int en_cnt = 0;
        logic [40:0] snap;
        logic exp_v;
        for (int t = 0; t < 25; t++) begin
            if (t < 3) drive(1'b1, 8'(t + 1), 16'd2487, 16'd0, 16'(t * 4096));
            else       drive(1'b0, 8'h00, 16'(t), 16'(3 * t), 16'(t * 999));
            enable = !(t >= 6 && t < 11);
            snap = {valid_out, code_out, x_out, y_out};
            step();
            if (enable) begin
                en_cnt++;
            end else begin
                total++;
                if ({valid_out, code_out, x_out, y_out} !== snap) begin
                    bad++;
                    $display("FAIL stall_frozen t=%0d got=%h want=%h", t,
                             {valid_out, code_out, x_out, y_out}, snap);
                end
            end
            exp_v = (en_cnt >= LAT && en_cnt <= LAT + 2);
            total++;
            if (valid_out !== exp_v ||
                (exp_v && code_out !== 8'(en_cnt - LAT + 1)) ||
                x_out !== pipe[0].x || y_out !== pipe[0].y) begin
                bad++;
                $display("FAIL stall_emerge t=%0d en=%0d got v=%b c=%0d x=%h y=%h want v=%b c=%0d x=%h y=%h",
                         t, en_cnt, valid_out, code_out, x_out, y_out,
                         exp_v, en_cnt - LAT + 1, pipe[0].x, pipe[0].y);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_saturation();
        drive(1'b1, 8'h11, 16'h7FFF, 16'h7FFF, 16'd0);
        step();
        drive(1'b1, 8'h22, 16'h8000, 16'h0000, 16'd0);
        step();
        drive(1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
        repeat (LAT - 2) step();
        total++;
        if (code_out !== 8'h11 || x_out !== 16'h7FFF || y_out !== 16'h7FFF) begin
            bad++;
            $display("FAIL sat_pos got c=%h x=%h y=%h want c=11 x=7fff y=7fff",
                     code_out, x_out, y_out);
        end
        step();
        total++;
        if (code_out !== 8'h22 || x_out !== 16'h8000 || y_out !== pipe[0].y) begin
            bad++;
            $display("FAIL sat_neg got c=%h x=%h y=%h want c=22 x=8000 y=%h",
                     code_out, x_out, y_out, pipe[0].y);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom));
            enable = ($urandom_range(0, 7) != 0);
            step();
            total++;
            if ({valid_out, code_out, x_out, y_out} !==
                {pipe[0].v, pipe[0].c, pipe[0].x, pipe[0].y}) begin
                bad++;
                $display("FAIL random_slot t=%0d got v=%b c=%h x=%h y=%h want v=%b c=%h x=%h y=%h",
                         t, valid_out, code_out, x_out, y_out,
                         pipe[0].v, pipe[0].c, pipe[0].x, pipe[0].y);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'(8'h40 + k), 16'd2487, 16'd100, 16'(k * 3000));
            step();
        end
        drive(1'b0, 8'h00, 16'd0, 16'd0, 16'd0);
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({valid_out, code_out, x_out, y_out} !== 41'd0) begin
            bad++;
            $display("FAIL reset_async got v=%b c=%h x=%h y=%h want all zero",
                     valid_out, code_out, x_out, y_out);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        pipe_clear();
        for (int t = 0; t < 2 * LAT; t++) begin
            step();
            total++;
            if (valid_out !== 1'b0 || code_out !== 8'h00 ||
                x_out !== 16'h0000 || y_out !== 16'h0000) begin
                bad++;
                $display("FAIL reset_stale t=%0d got v=%b c=%h x=%h y=%h want all zero",
                         t, valid_out, code_out, x_out, y_out);
            end
        end
    endtask

    initial begin
        kgain = 1.0;
        for (int i = 0; i < 12; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
        test_reset();
        test_latency();
        test_quadrants();
        test_back_to_back();
        test_stall();
        test_saturation();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
